// File: rtl/alu_pkg.sv
// alu_pkg: op codes, scheduler state encoding and op classification shared by the ALU scheduler
package alu_pkg;
   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_NOT  = 4'b0010;
   localparam logic [3:0] OP_NOR  = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_NAND = 4'b0101;
   localparam logic [3:0] OP_ADD  = 4'b0110;
   localparam logic [3:0] OP_SUB  = 4'b0111;
   typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;
   function automatic logic is_arith(input logic [3:0] op);
      return op == OP_ADD || op == OP_SUB;
   endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-request round-robin grant; the pointer names the favoured requester on a tie or when idle
module rr_arb2 (
   input  logic clk,
   input  logic rst,
   input  logic valid0,
   input  logic valid1,
   input  logic accept,
   output logic grant0,
   output logic grant1
);
   logic ptr;
   // a lone valid requester wins, otherwise the pointer decides
   always_comb begin
      grant1 = (valid0 ^ valid1) ? valid1 : ptr;
      grant0 = ~grant1;
   end
   // after each accept favour the requester that was not just served
   always_ff @(posedge clk) begin
      if (rst) ptr <= 1'b0;
      else if (accept) ptr <= ~grant1;
   end
endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: shares one 32-bit ALU between two requesters, chaining two passes for 64-bit ops
module alu_scheduler
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_op,
   input  logic        req0_wide,
   input  logic [63:0] req0_a,
   input  logic [63:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_op,
   input  logic        req1_wide,
   input  logic [63:0] req1_a,
   input  logic [63:0] req1_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [63:0] rsp_y,
   output logic        rsp_cout,
   output logic        rsp_neg,
   output logic        rsp_zero,
   output logic        rsp_ovf,
   output logic        rsp_err,
   output logic [31:0] alu_A,
   output logic [31:0] alu_B,
   output logic [3:0]  alu_sel,
   output logic        alu_Cin,
   input  logic [31:0] alu_Y,
   input  logic        alu_Cout,
   input  logic        alu_Negative,
   input  logic        alu_Zero,
   input  logic        alu_Overflow
);
   state_t state;
   logic [3:0] op;
   logic wide;
   logic [63:0] a, b;
   logic grant0, grant1, idle, accept, pass_lo, pass_hi, arith;
   logic [3:0] sel_op;
   logic sel_wide;
   logic [63:0] sel_a, sel_b;
   rr_arb2 u_arb (
      .clk(clk), .rst(rst), .valid0(req0_valid), .valid1(req1_valid),
      .accept(accept), .grant0(grant0), .grant1(grant1)
   );
   // handshake decode, selected request fields and ALU drive; the ALU sees zeros outside its passes
   always_comb begin
      idle = state == IDLE;
      pass_lo = state == LO;
      pass_hi = state == HI;
      arith = is_arith(op);
      req0_ready = idle & grant0;
      req1_ready = idle & grant1;
      accept = (req0_valid & req0_ready) | (req1_valid & req1_ready);
      sel_op = grant1 ? req1_op : req0_op;
      sel_wide = grant1 ? req1_wide : req0_wide;
      sel_a = grant1 ? req1_a : req0_a;
      sel_b = grant1 ? req1_b : req0_b;
      rsp_valid = state == RESP;
      alu_A = pass_lo ? a[31:0] : pass_hi ? a[63:32] : '0;
      alu_B = pass_lo ? b[31:0] : pass_hi ? b[63:32] : '0;
      alu_sel = (pass_lo | pass_hi) ? op : '0;
      alu_Cin = pass_lo ? op == OP_SUB : pass_hi & arith & rsp_cout;
   end
   // sequencer: capture on accept, LO then optional HI pass, hold the response until taken
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         op <= '0;
         wide <= 1'b0;
         a <= '0;
         b <= '0;
         rsp_id <= 1'b0;
         rsp_y <= '0;
         {rsp_cout, rsp_neg, rsp_zero, rsp_ovf, rsp_err} <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               op <= sel_op;
               wide <= sel_wide;
               a <= sel_a;
               b <= sel_b;
               rsp_id <= grant1;
               rsp_y <= '0;
               {rsp_cout, rsp_neg, rsp_zero, rsp_ovf} <= '0;
               rsp_err <= sel_op[3];
               state <= sel_op[3] ? RESP : LO;
            end
            LO: begin
               rsp_y[31:0] <= alu_Y;
               rsp_cout <= arith & alu_Cout;
               rsp_neg <= alu_Negative;
               rsp_zero <= alu_Zero;
               rsp_ovf <= arith & alu_Overflow;
               state <= wide ? HI : RESP;
            end
            HI: begin
               rsp_y[63:32] <= alu_Y;
               rsp_cout <= arith & alu_Cout;
               rsp_neg <= alu_Negative;
               rsp_zero <= rsp_zero & alu_Zero;
               rsp_ovf <= arith & alu_Overflow;
               state <= RESP;
            end
            RESP: if (rsp_ready) state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: directed checks of arbitration, pass sequencing, flags, backpressure and reset
module tb_alu_scheduler;
   import alu_pkg::*;
   logic clk = 1'b0, rst = 1'b1;
   logic req0_valid = 0, req0_ready, req0_wide = 0, req1_valid = 0, req1_ready, req1_wide = 0;
   logic [3:0] req0_op = 0, req1_op = 0;
   logic [63:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic rsp_valid, rsp_ready = 0, rsp_id, rsp_cout, rsp_neg, rsp_zero, rsp_ovf, rsp_err;
   logic [63:0] rsp_y;
   logic [31:0] alu_A, alu_B, alu_Y, bx;
   logic [3:0] alu_sel;
   logic alu_Cin, alu_Cout, alu_Negative, alu_Zero, alu_Overflow;
   logic [32:0] sum;
   int vecs = 0, miscompares = 0;

   alu_scheduler dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_wide(req0_wide),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_wide(req1_wide),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
      .rsp_cout(rsp_cout), .rsp_neg(rsp_neg), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
      .alu_A(alu_A), .alu_B(alu_B), .alu_sel(alu_sel), .alu_Cin(alu_Cin),
      .alu_Y(alu_Y), .alu_Cout(alu_Cout), .alu_Negative(alu_Negative), .alu_Zero(alu_Zero),
      .alu_Overflow(alu_Overflow)
   );

   always #5 clk = ~clk;

   // reference ALU; logic ops report junk carry/overflow so the scheduler must mask them
   always_comb begin
      bx = alu_sel == OP_SUB ? ~alu_B : alu_B;
      sum = {1'b0, alu_A} + {1'b0, bx} + {32'd0, alu_Cin};
      alu_Y = alu_sel == OP_AND  ? alu_A & alu_B :
              alu_sel == OP_OR   ? alu_A | alu_B :
              alu_sel == OP_NOT  ? ~alu_A :
              alu_sel == OP_NOR  ? ~(alu_A | alu_B) :
              alu_sel == OP_XOR  ? alu_A ^ alu_B :
              alu_sel == OP_NAND ? ~(alu_A & alu_B) : sum[31:0];
      alu_Cout = is_arith(alu_sel) ? sum[32] : 1'b1;
      alu_Overflow = is_arith(alu_sel) ? (alu_A[31] == bx[31]) && (sum[31] != alu_A[31]) : 1'b1;
      alu_Negative = alu_Y[31];
      alu_Zero = alu_Y == 32'd0;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_alu_idle(input string tag);
      chk({tag, "_alu"}, {alu_A, alu_B, alu_sel, alu_Cin}, 64'd0);
      chk({tag, "_alusel"}, {63'd0, alu_Cin} | {60'd0, alu_sel}, 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      step();
      step();
      chk("rst_valid", rsp_valid, 0);
      chk("rst_y", rsp_y, 0);
      chk("rst_flags", {rsp_id, rsp_cout, rsp_neg, rsp_zero, rsp_ovf, rsp_err}, 0);
      chk_alu_idle("rst");
      rst = 0;
      #1;
      chk("rst_ready", {req0_ready, req1_ready}, 2'b10);

      // narrow ADD on req0: signed overflow into bit 31
      req0_valid = 1; req0_op = OP_ADD; req0_wide = 0; req0_a = 64'h0000_0000_7FFF_FFFF; req0_b = 64'd1;
      #1;
      chk("add_ready0", req0_ready, 1);
      step();
      req0_valid = 0;
      chk("add_lo_valid", rsp_valid, 0);
      chk("add_lo_drive", {alu_A, alu_B}, {32'h7FFF_FFFF, 32'd1});
      chk("add_lo_sel_cin", {alu_sel, alu_Cin}, {OP_ADD, 1'b0});
      chk("add_lo_ready", {req0_ready, req1_ready}, 0);
      step();
      chk("add_valid", rsp_valid, 1);
      chk("add_y", rsp_y, 64'h0000_0000_8000_0000);
      chk("add_flags", {rsp_id, rsp_cout, rsp_neg, rsp_zero, rsp_ovf, rsp_err}, 6'b001010);
      chk_alu_idle("add_resp");
      rsp_ready = 1;
      step();
      rsp_ready = 0;
      chk("add_done", rsp_valid, 0);

      // wide ADD on req1: low-word carry chains into the high pass
      req1_valid = 1; req1_op = OP_ADD; req1_wide = 1; req1_a = 64'h0000_0000_FFFF_FFFF; req1_b = 64'd1;
      #1;
      chk("wadd_ready", {req0_ready, req1_ready}, 2'b01);
      step();
      req1_valid = 0;
      chk("wadd_lo", {alu_A, alu_B}, {32'hFFFF_FFFF, 32'd1});
      chk("wadd_lo_cin", alu_Cin, 0);
      step();
      chk("wadd_hi_cin", alu_Cin, 1);
      chk("wadd_hi_valid", rsp_valid, 0);
      step();
      chk("wadd_valid", rsp_valid, 1);
      chk("wadd_y", rsp_y, 64'h0000_0001_0000_0000);
      chk("wadd_flags", {rsp_id, rsp_cout, rsp_neg, rsp_zero, rsp_ovf, rsp_err}, 6'b100000);
      rsp_ready = 1;
      step();
      rsp_ready = 0;

      // wide SUB on req0 with equal operands, then backpressure
      req0_valid = 1; req0_op = OP_SUB; req0_wide = 1; req0_a = 64'h1234_5678_9ABC_DEF0; req0_b = 64'h1234_5678_9ABC_DEF0;
      #1;
      chk("wsub_ready", {req0_ready, req1_ready}, 2'b10);
      step();
      req0_valid = 0;
      chk("wsub_lo_cin", alu_Cin, 1);
      step();
      chk("wsub_hi", {alu_A, alu_B}, {32'h1234_5678, 32'h1234_5678});
      step();
      req1_valid = 1; req1_op = 4'b1010; req1_wide = 0; req1_a = 64'hDEAD; req1_b = 64'hBEEF;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", rsp_valid, 1);
         chk("bp_y", rsp_y, 0);
         chk("bp_flags", {rsp_id, rsp_cout, rsp_neg, rsp_zero, rsp_ovf, rsp_err}, 6'b010100);
         chk("bp_ready", {req0_ready, req1_ready}, 0);
         step();
      end
      rsp_ready = 1;
      #1;
      chk("bp_hs_ready", {req0_ready, req1_ready}, 0);
      step();
      rsp_ready = 0;
      chk("bp_idle_valid", rsp_valid, 0);
      chk("ill_ready", {req0_ready, req1_ready}, 2'b01);
      chk_alu_idle("ill_accept");

      // illegal op accepted this cycle: response straight away, no ALU pass
      step();
      req1_valid = 0;
      chk("ill_valid", rsp_valid, 1);
      chk("ill_y", rsp_y, 0);
      chk("ill_flags", {rsp_id, rsp_cout, rsp_neg, rsp_zero, rsp_ovf, rsp_err}, 6'b100001);
      chk_alu_idle("ill_resp");
      rsp_ready = 1;
      step();

      // both requesters continuously valid with XORs: grants alternate
      req0_valid = 1; req0_op = OP_XOR; req0_wide = 0; req0_a = 64'hAAAA_BBBB_1111_0000; req0_b = 64'h0000_0000_0000_FFFF;
      req1_valid = 1; req1_op = OP_XOR; req1_wide = 0; req1_a = 64'h0F0F_0F0F; req1_b = 64'hFFFF_FFFF;
      for (int k = 0; k < 8; k++) begin
         for (int n = 0; n < 6 && !rsp_valid; n++) step();
         chk("rr_valid", rsp_valid, 1);
         chk("rr_id", rsp_id, k[0]);
         chk("rr_y", rsp_y, k[0] ? 64'hF0F0_F0F0 : 64'h1111_FFFF);
         chk("rr_flags", {rsp_cout, rsp_neg, rsp_zero, rsp_ovf, rsp_err}, {1'b0, k[0], 3'b000});
         if (k == 7) begin
            req0_valid = 0;
            req1_valid = 0;
         end
         step();
      end
      rsp_ready = 0;
      chk("rr_end", rsp_valid, 0);

      // reset during the high pass drops the op and rewinds the pointer
      req0_valid = 1; req0_op = OP_ADD; req0_wide = 1; req0_a = 64'h5; req0_b = 64'h7;
      step();
      req0_valid = 0;
      step();
      chk("rst_hi_state", {alu_sel, alu_A}, {OP_ADD, 32'd0});
      rst = 1;
      step();
      rst = 0;
      #1;
      chk("rst_hi_valid", rsp_valid, 0);
      chk("rst_hi_ready", {req0_ready, req1_ready}, 2'b10);
      chk_alu_idle("rst_hi");
      step();
      chk("rst_hi_still", rsp_valid, 0);
      req0_valid = 1; req1_valid = 1;
      #1;
      chk("rst_hi_ptr", {req0_ready, req1_ready}, 2'b10);
      req0_valid = 0; req1_valid = 0;
      step();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end
endmodule
